// File: rtl/mem_access_unit_if.sv
// Bundle of the execute-stage handshake, the data-memory bus and the writeback record
// seen by the memory stage. "master" is the memory stage itself, "slave" its environment.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
);
    logic              ex_valid;
    logic              ex_ready;
    logic [ADDR_W-1:0] ex_alu_result;
    logic [31:0]       ex_store_data;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [2:0]        ex_funct3;
    logic [RD_W-1:0]   ex_rd;
    logic              ex_reg_write;

    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    logic              wb_valid;
    logic [RD_W-1:0]   wb_rd;
    logic [31:0]       wb_data;
    logic              wb_reg_write;
    logic              wb_misaligned;

    modport master (
        input  ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
               ex_funct3, ex_rd, ex_reg_write, mem_ack, mem_rdata,
        output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               wb_valid, wb_rd, wb_data, wb_reg_write, wb_misaligned
    );

    modport slave (
        output ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
               ex_funct3, ex_rd, ex_reg_write, mem_ack, mem_rdata,
        input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               wb_valid, wb_rd, wb_data, wb_reg_write, wb_misaligned
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: issues aligned load/store requests on a req/ack bus, extends load data and
// emits one registered writeback record per accepted instruction.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.master bus
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUS = 1'b1} state_t;

    function automatic logic misaligned_f(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: misaligned_f = 1'b0;
            3'b001, 3'b101: misaligned_f = a[0];
            3'b010:         misaligned_f = (a != 2'b00);
            default:        misaligned_f = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_strb_f(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   store_strb_f = 4'b0001 << a;
            2'b01:   store_strb_f = 4'b0011 << a;
            default: store_strb_f = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data_f(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_data_f = {4{d[7:0]}};
            2'b01:   store_data_f = {2{d[15:0]}};
            default: store_data_f = d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext_f(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] d);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = d[{a, 3'b000} +: 8];
        half_v = d[{a[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_ext_f = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_ext_f = {24'h000000, byte_v};
            3'b001:  load_ext_f = {{16{half_v[15]}}, half_v};
            3'b101:  load_ext_f = {16'h0000, half_v};
            default: load_ext_f = d;
        endcase
    endfunction

    state_t          state_r, state_next_s;
    logic            ex_ready_r, ex_ready_s;
    logic            mem_req_r, mem_req_s, mem_we_r, mem_we_s;
    logic [31:0]     mem_addr_r, mem_addr_s, mem_wdata_r, mem_wdata_s;
    logic [3:0]      mem_wstrb_r, mem_wstrb_s;
    logic            wb_valid_r, wb_valid_s, wb_reg_write_r, wb_reg_write_s;
    logic            wb_mis_r, wb_mis_s;
    logic [RD_W-1:0] wb_rd_r, wb_rd_s, rd_r, rd_s;
    logic [31:0]     wb_data_r, wb_data_s;
    logic [2:0]      f3_r, f3_s;
    logic [1:0]      lane_r, lane_s;
    logic            rw_r, rw_s;

    logic [31:0]     addr32_s;
    logic            accept_s, is_mem_s, mis_s;

    assign addr32_s = 32'(bus.ex_alu_result);
    // ex_ready_r is only ever high in IDLE, so it alone qualifies acceptance
    assign accept_s = bus.ex_valid & ex_ready_r;
    assign is_mem_s = bus.ex_mem_read | bus.ex_mem_write;
    assign mis_s    = misaligned_f(bus.ex_funct3, addr32_s[1:0]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mem_s && !mis_s) begin
                    state_next_s = ST_BUS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (bus.mem_ack) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BUS;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output/capture logic: next values for every registered output
    always_comb begin
        ex_ready_s     = (state_next_s == ST_IDLE);
        mem_req_s      = 1'b0;
        mem_we_s       = mem_we_r;
        mem_addr_s     = mem_addr_r;
        mem_wdata_s    = mem_wdata_r;
        mem_wstrb_s    = mem_wstrb_r;
        wb_valid_s     = 1'b0;
        wb_rd_s        = wb_rd_r;
        wb_data_s      = wb_data_r;
        wb_reg_write_s = wb_reg_write_r;
        wb_mis_s       = wb_mis_r;
        f3_s           = f3_r;
        lane_s         = lane_r;
        rd_s           = rd_r;
        rw_s           = rw_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !is_mem_s) begin
                    wb_valid_s     = 1'b1;
                    wb_rd_s        = bus.ex_rd;
                    wb_data_s      = addr32_s;
                    wb_reg_write_s = bus.ex_reg_write;
                    wb_mis_s       = 1'b0;
                end else if (accept_s && mis_s) begin
                    wb_valid_s     = 1'b1;
                    wb_rd_s        = bus.ex_rd;
                    wb_data_s      = addr32_s;
                    wb_reg_write_s = 1'b0;
                    wb_mis_s       = 1'b1;
                end else if (accept_s) begin
                    // a set write flag wins over the read flag
                    mem_req_s   = 1'b1;
                    mem_we_s    = bus.ex_mem_write;
                    mem_addr_s  = {addr32_s[31:2], 2'b00};
                    mem_wdata_s = bus.ex_mem_write ? store_data_f(bus.ex_funct3, bus.ex_store_data) : 32'h0000_0000;
                    mem_wstrb_s = bus.ex_mem_write ? store_strb_f(bus.ex_funct3, addr32_s[1:0]) : 4'b0000;
                    f3_s        = bus.ex_funct3;
                    lane_s      = addr32_s[1:0];
                    rd_s        = bus.ex_rd;
                    rw_s        = bus.ex_reg_write;
                end else begin
                    mem_req_s = 1'b0;
                end
            end
            ST_BUS: begin
                if (bus.mem_ack) begin
                    wb_valid_s     = 1'b1;
                    wb_rd_s        = rd_r;
                    wb_mis_s       = 1'b0;
                    wb_reg_write_s = mem_we_r ? 1'b0 : rw_r;
                    wb_data_s      = mem_we_r ? wb_data_r : load_ext_f(f3_r, lane_r, bus.mem_rdata);
                end else begin
                    mem_req_s = 1'b1;
                end
            end
            default: mem_req_s = 1'b0;
        endcase
    end

    // Output and capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ready_r     <= 1'b0;
            mem_req_r      <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= 32'h0000_0000;
            mem_wdata_r    <= 32'h0000_0000;
            mem_wstrb_r    <= 4'b0000;
            wb_valid_r     <= 1'b0;
            wb_rd_r        <= '0;
            wb_data_r      <= 32'h0000_0000;
            wb_reg_write_r <= 1'b0;
            wb_mis_r       <= 1'b0;
            f3_r           <= 3'b000;
            lane_r         <= 2'b00;
            rd_r           <= '0;
            rw_r           <= 1'b0;
        end else begin
            ex_ready_r     <= ex_ready_s;
            mem_req_r      <= mem_req_s;
            mem_we_r       <= mem_we_s;
            mem_addr_r     <= mem_addr_s;
            mem_wdata_r    <= mem_wdata_s;
            mem_wstrb_r    <= mem_wstrb_s;
            wb_valid_r     <= wb_valid_s;
            wb_rd_r        <= wb_rd_s;
            wb_data_r      <= wb_data_s;
            wb_reg_write_r <= wb_reg_write_s;
            wb_mis_r       <= wb_mis_s;
            f3_r           <= f3_s;
            lane_r         <= lane_s;
            rd_r           <= rd_s;
            rw_r           <= rw_s;
        end
    end

    assign bus.ex_ready      = ex_ready_r;
    assign bus.mem_req       = mem_req_r;
    assign bus.mem_we        = mem_we_r;
    assign bus.mem_addr      = mem_addr_r;
    assign bus.mem_wdata     = mem_wdata_r;
    assign bus.mem_wstrb     = mem_wstrb_r;
    assign bus.wb_valid      = wb_valid_r;
    assign bus.wb_rd         = wb_rd_r;
    assign bus.wb_data       = wb_data_r;
    assign bus.wb_reg_write  = wb_reg_write_r;
    assign bus.wb_misaligned = wb_mis_r;
endmodule
